// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// buffers up to two returned instructions for the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_hazard,
    input  logic              control_hazard,
    input  logic [31:0]       redirect_pc,
    if_fetch_if.master        imem,
    output logic [31:0]       IF_inst,
    output logic [31:0]       IF_pc,
    output logic [31:0]       IF_pc4
);

    logic [31:0] fetch_pc_r;
    logic [31:0] oq_pc_r [2];
    logic        oq_rd_ptr_r;
    logic        oq_wr_ptr_r;
    logic [1:0]  out_cnt_r;
    logic [31:0] buf_pc_r [2];
    logic [31:0] buf_inst_r [2];
    logic        buf_rd_ptr_r;
    logic        buf_wr_ptr_r;
    logic [1:0]  buf_cnt_r;
    logic [1:0]  drop_cnt_r;

    logic        pop_s;
    logic [2:0]  credit_s;
    logic        req_s;
    logic        accept_s;
    logic        rsp_drop_s;
    logic        rsp_keep_s;
    logic [1:0]  drop_sum_s;

    assign pop_s      = (buf_cnt_r != 2'd0) & ~data_hazard & ~control_hazard;
    // Stale responses still awaiting discard occupy credit like live ones.
    assign credit_s   = {1'b0, out_cnt_r} + {1'b0, drop_cnt_r} + {1'b0, buf_cnt_r}
                      - {2'b00, pop_s};
    assign req_s      = rst & ~control_hazard & (credit_s < 3'd2);
    assign accept_s   = req_s & imem.imem_ready;
    assign rsp_drop_s = imem.imem_rvalid & (drop_cnt_r != 2'd0);
    assign rsp_keep_s = imem.imem_rvalid & (drop_cnt_r == 2'd0) & (out_cnt_r != 2'd0);
    assign drop_sum_s = drop_cnt_r + out_cnt_r;

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = fetch_pc_r;

    // Present the buffer head downstream, or an all-zero bubble when empty.
    always_comb begin
        IF_inst = 32'd0;
        IF_pc   = 32'd0;
        IF_pc4  = 32'd0;
        if (buf_cnt_r != 2'd0) begin
            IF_inst = buf_inst_r[buf_rd_ptr_r];
            IF_pc   = buf_pc_r[buf_rd_ptr_r];
            IF_pc4  = buf_pc_r[buf_rd_ptr_r] + 32'd4;
        end else begin
            IF_inst = 32'd0;
            IF_pc   = 32'd0;
            IF_pc4  = 32'd0;
        end
    end

    // PC, in-flight address queue, instruction buffer and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            oq_pc_r[0]    <= 32'd0;
            oq_pc_r[1]    <= 32'd0;
            oq_rd_ptr_r   <= 1'b0;
            oq_wr_ptr_r   <= 1'b0;
            out_cnt_r     <= 2'd0;
            buf_pc_r[0]   <= 32'd0;
            buf_pc_r[1]   <= 32'd0;
            buf_inst_r[0] <= 32'd0;
            buf_inst_r[1] <= 32'd0;
            buf_rd_ptr_r  <= 1'b0;
            buf_wr_ptr_r  <= 1'b0;
            buf_cnt_r     <= 2'd0;
            drop_cnt_r    <= 2'd0;
        end else if (control_hazard) begin
            fetch_pc_r   <= redirect_pc;
            oq_rd_ptr_r  <= 1'b0;
            oq_wr_ptr_r  <= 1'b0;
            out_cnt_r    <= 2'd0;
            buf_rd_ptr_r <= 1'b0;
            buf_wr_ptr_r <= 1'b0;
            buf_cnt_r    <= 2'd0;
            // A response landing in this very cycle is one of the outstanding ones.
            if (imem.imem_rvalid && (drop_sum_s != 2'd0)) begin
                drop_cnt_r <= drop_sum_s - 2'd1;
            end else begin
                drop_cnt_r <= drop_sum_s;
            end
        end else begin
            if (accept_s) begin
                oq_pc_r[oq_wr_ptr_r] <= fetch_pc_r;
                oq_wr_ptr_r          <= ~oq_wr_ptr_r;
                fetch_pc_r           <= fetch_pc_r + 32'd4;
            end
            if (rsp_drop_s) begin
                drop_cnt_r <= drop_cnt_r - 2'd1;
            end
            if (rsp_keep_s) begin
                buf_pc_r[buf_wr_ptr_r]   <= oq_pc_r[oq_rd_ptr_r];
                buf_inst_r[buf_wr_ptr_r] <= imem.imem_rdata;
                buf_wr_ptr_r             <= ~buf_wr_ptr_r;
                oq_rd_ptr_r              <= ~oq_rd_ptr_r;
            end
            if (pop_s) begin
                buf_rd_ptr_r <= ~buf_rd_ptr_r;
            end
            out_cnt_r <= out_cnt_r + {1'b0, accept_s} - {1'b0, rsp_keep_s};
            buf_cnt_r <= buf_cnt_r + {1'b0, rsp_keep_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: randomized memory/hazards against a PC-sequence reference model.
module tb_if_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_hazard;
    logic        control_hazard;
    logic [31:0] redirect_pc;
    logic [31:0] if_inst, if_pc, if_pc4;
    logic [31:0] inst80, pc80, pc4_80;
    logic        tie0;
    logic        rv80;
    logic [31:0] rd80;

    always #5 clk = ~clk;

    if_fetch_if bus ();
    if_fetch_if bus80 ();

    if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_hazard    (data_hazard),
        .control_hazard (control_hazard),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .IF_inst        (if_inst),
        .IF_pc          (if_pc),
        .IF_pc4         (if_pc4)
    );

    if_fetch #(.RESET_PC(32'h0000_0080)) u_dut80 (
        .clk            (clk),
        .rst            (rst),
        .data_hazard    (tie0),
        .control_hazard (tie0),
        .redirect_pc    (32'h0000_0000),
        .imem           (bus80),
        .IF_inst        (inst80),
        .IF_pc          (pc80),
        .IF_pc4         (pc4_80)
    );

    // Ideal one-cycle memory for the second instance, reset with the pipeline.
    assign tie0               = 1'b0;
    assign bus80.imem_ready   = 1'b1;
    assign bus80.imem_rvalid  = rv80;
    assign bus80.imem_rdata   = rd80;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv80 <= 1'b0;
            rd80 <= 32'd0;
        end else begin
            rv80 <= bus80.imem_req;
            rd80 <= bus80.imem_addr ^ KEY;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rdy_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    logic [31:0] exp_pc, exp_fetch;
    int          owed, pops;
    logic        prev_hold;

    logic [31:0] obs_inst, obs_pc, obs_pc4, obs_addr, obs_inst80, obs_pc80, obs_pc4_80;
    logic        obs_req;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // One clock cycle: drive memory, observe, check against model, advance.
    task automatic step();
        logic valid, acc, pop;
        logic [31:0] a;
        bus.imem_ready = ($urandom_range(0, 99) < rdy_pct);
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
        end
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = a ^ KEY;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        obs_inst = if_inst; obs_pc = if_pc; obs_pc4 = if_pc4;
        obs_req = bus.imem_req; obs_addr = bus.imem_addr;
        obs_inst80 = inst80; obs_pc80 = pc80; obs_pc4_80 = pc4_80;
        if (!rst) begin
            check_val("rst_inst", obs_inst, 32'd0);
            check_val("rst_pc", obs_pc | obs_pc4, 32'd0);
            check_val("rst_req", 32'(obs_req), 32'd0);
            exp_pc = 32'd0; exp_fetch = 32'd0; owed = 0; prev_hold = 1'b0;
        end else begin
            valid = (obs_inst != 32'd0);
            if (valid) begin
                check_val("pc_seq", obs_pc, exp_pc);
                check_val("pc4", obs_pc4, exp_pc + 32'd4);
                check_val("inst", obs_inst, exp_pc ^ KEY);
            end else begin
                check_val("bubble", obs_pc | obs_pc4, 32'd0);
            end
            if (prev_hold) check_val("hold_valid", 32'(valid), 32'd1);
            if (control_hazard) check_val("req_on_flush", 32'(obs_req), 32'd0);
            else if (obs_req) check_val("fetch_addr", obs_addr, exp_fetch);
            acc = obs_req & bus.imem_ready;
            pop = valid & ~data_hazard & ~control_hazard;
            if (acc) begin
                mq_addr.push_back(obs_addr);
                mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            end
            if (control_hazard) begin
                exp_pc = redirect_pc; exp_fetch = redirect_pc; owed = 0;
            end else begin
                if (pop) begin exp_pc += 32'd4; owed--; pops++; end
                if (acc) begin exp_fetch += 32'd4; owed++; end
            end
            check_val("occupancy", 32'(owed <= 2), 32'd1);
            prev_hold = valid & data_hazard & ~control_hazard;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int k, p0;
        rst = 1'b0; data_hazard = 1'b0; control_hazard = 1'b0; redirect_pc = 32'd0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        pops = 0;
        @(negedge clk);
        step(); step();

        // Reset release with ideal memory, then a 4-cycle hold at pc 8.
        rst = 1'b1;
        step();
        check_val("t1_req0", 32'(obs_req), 32'd1);
        check_val("t1_addr0", obs_addr, 32'd0);
        check_val("t1_bub0", obs_inst, 32'd0);
        step();
        check_val("t1_bub1", obs_inst, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("t1_pc", obs_pc, 32'(i * 4));
            check_val("t1_pc4", obs_pc4, 32'(i * 4 + 4));
        end
        data_hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t2_hold_pc", obs_pc, 32'd8);
            check_val("t2_req_off", 32'(obs_req), 32'd0);
        end
        data_hazard = 1'b0;
        step();
        check_val("t2_rel_pc", obs_pc, 32'd8);
        check_val("t2_rel_req", 32'(obs_req), 32'd1);
        check_val("t2_rel_addr", obs_addr, 32'd16);
        step();
        check_val("t2_pc12", obs_pc, 32'd12);
        step();
        check_val("t2_pc16", obs_pc, 32'd16);

        // Redirect to 0x100 with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 8; i++) step();
        k = 0;
        while (mq_addr.size() != 2 && k < 10) begin step(); k++; end
        control_hazard = 1'b1; redirect_pc = 32'h100;
        step();
        control_hazard = 1'b0;
        k = 0;
        do begin step(); k++; end while (obs_inst == 32'd0 && k < 20);
        check_val("t3_target", obs_pc, 32'h100);

        // Redirect coinciding with a response and a data hazard.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step();
        control_hazard = 1'b1; data_hazard = 1'b1; redirect_pc = 32'h200;
        step();
        control_hazard = 1'b0; data_hazard = 1'b0;
        step();
        check_val("t5_bubble", obs_inst, 32'd0);
        check_val("t5_req", 32'(obs_req), 32'd1);
        check_val("t5_addr", obs_addr, 32'h200);
        k = 0;
        do begin step(); k++; end while (obs_inst == 32'd0 && k < 4);
        check_val("t5_target", obs_pc, 32'h200);

        // Random ready, latency and hazards.
        rdy_pct = 50; lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            data_hazard    = ($urandom_range(0, 99) < 25);
            control_hazard = ($urandom_range(0, 99) < 3);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            step();
        end
        data_hazard = 1'b0; control_hazard = 1'b0;
        check_val("t4_progress", 32'((pops - p0) > 100), 32'd1);

        // Reset pulse mid-stream; second instance restarts at 0x80.
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b0;
        step();
        check_val("t6_rst_inst80", obs_inst80, 32'd0);
        check_val("t6_rst_pc80", obs_pc80 | obs_pc4_80, 32'd0);
        rst = 1'b1;
        k = 0;
        do begin step(); k++; end while (obs_inst80 == 32'd0 && k < 6);
        check_val("t6_pc80", obs_pc80, 32'h80);
        check_val("t6_inst80", obs_inst80, 32'h80 ^ KEY);
        check_val("t6_pc4_80", obs_pc4_80, 32'h84);
        step();
        check_val("t6_pc84", obs_pc80, 32'h84);
        for (int i = 0; i < 6; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
